// File: rtl/uart_hex_loader.sv
// ASCII hex token loader: parses separator-delimited hex tokens from the UART
// receive stream and writes each value into the operand buffer.
module uart_hex_loader #(
  parameter int NUM_VALUES = 32,
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 2,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  count,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int ND_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_SEP, S_DIGIT, S_DONE, S_ERR} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [ND_W-1:0]   ndig, ndig_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
  logic [CNT_W-1:0]  count_n, count_inc;
  logic [1:0]        err_n;
  logic              is_digit, is_sep;
  logic [3:0]        nibble;

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = rx_byte[3:0] + 4'd9;
    end
    is_sep = (rx_byte == 8'h20) || (rx_byte == 8'h09) || (rx_byte == 8'h0D) ||
             (rx_byte == 8'h0A) || (rx_byte == 8'h2C);
  end

  assign count_inc = count + CNT_W'(1);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ndig_n    = ndig;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    count_n   = count;
    err_n     = err_code;
    // clear wins over a coincident byte; a write issued last cycle still lands
    if (clear) begin
      state_n = S_SEP;
      acc_n   = '0;
      ndig_n  = '0;
      count_n = '0;
      err_n   = 2'd0;
    end else if (rx_valid) begin
      unique case (state)
        S_SEP: begin
          if (is_digit) begin
            acc_n   = DATA_W'(nibble);
            ndig_n  = ND_W'(1);
            state_n = S_DIGIT;
          end else if (!is_sep) begin
            state_n = S_ERR;
            err_n   = 2'd1;
          end
        end
        S_DIGIT: begin
          if (is_digit) begin
            if (ndig == ND_W'(MAX_DIGITS)) begin
              state_n = S_ERR;
              err_n   = 2'd2;
            end else begin
              acc_n  = {acc[DATA_W-5:0], nibble};
              ndig_n = ndig + ND_W'(1);
            end
          end else if (is_sep) begin
            wr_en_n   = 1'b1;
            wr_addr_n = count[ADDR_W-1:0];
            wr_data_n = acc;
            count_n   = count_inc;
            acc_n     = '0;
            ndig_n    = '0;
            state_n   = (count_inc == CNT_W'(NUM_VALUES)) ? S_DONE : S_SEP;
          end else begin
            state_n = S_ERR;
            err_n   = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_SEP;
      acc      <= '0;
      ndig     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      err_code <= 2'd0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      ndig     <= ndig_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      count    <= count_n;
      err_code <= err_n;
    end
  end

  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

endmodule

// File: tb/tb_uart_hex_loader.sv
// Randomized + directed bench for uart_hex_loader; expected writes are queued by
// a token-level model and checked by an independent negedge monitor.
module tb_uart_hex_loader;
  localparam int NV = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       clear = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] count;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  uart_hex_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cnt;
    int dn;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   neg_cnt = 0;

  // model: mode 0 between tokens, 1 in token, 2 done, 3 error
  int      m_mode = 0;
  int      m_cnt = 0;
  int      m_code = 0;
  byte     m_tok[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic bit is_hex(input byte b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic bit is_sep(input byte b);
    return b == 8'h20 || b == 8'h09 || b == 8'h0D || b == 8'h0A || b == 8'h2C;
  endfunction

  function automatic int hexval(input byte b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_code = 0; m_tok.delete();
  endtask

  task automatic model_byte(input byte b, input bit clr);
    exp_t e;
    int v;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_mode >= 2) return;
    if (is_hex(b)) begin
      if (m_tok.size() == 2) begin m_mode = 3; m_code = 2; m_tok.delete(); end
      else begin m_tok.push_back(b); m_mode = 1; end
    end else if (is_sep(b)) begin
      if (m_mode == 1) begin
        v = 0;
        foreach (m_tok[i]) v = v * 16 + hexval(m_tok[i]);
        e.addr = m_cnt; e.data = v; e.cnt = m_cnt + 1;
        e.dn = (m_cnt + 1 == NV); e.due = neg_cnt + 1;
        q.push_back(e);
        m_cnt++;
        m_tok.delete();
        m_mode = e.dn ? 2 : 0;
      end
    end else begin
      m_mode = 3; m_code = 1; m_tok.delete();
    end
  endtask

  // called at #1 after a posedge; returns at #1 after the next posedge
  task automatic drive(input byte b, input bit clr);
    rx_valid = 1'b1; rx_byte = b; clear = clr;
    @(posedge clk);
    model_byte(b, clr);
    #1;
    rx_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b0);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    model_byte(8'h00, 1'b1);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_status(input string tag);
    idle(2);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".done"}, int'(done), int'(m_mode == 2));
    chk({tag, ".error"}, int'(error), int'(m_mode == 3));
    chk({tag, ".err_code"}, int'(err_code), m_code);
    chk({tag, ".pending"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (wr_en) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", wr_addr, wr_data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("wr_latency", neg_cnt, e.due);
        chk("count_at_write", int'(count), e.cnt);
        chk("done_at_write", int'(done), e.dn);
      end
    end else if (q.size() > 0 && q[0].due < neg_cnt) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_write: no wr_en, expected addr=%0d data=0x%0h", e.addr, e.data);
    end
  end

  initial begin
    string s;
    int r;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.wr_en", int'(wr_en), 0);
    chk("reset.wr_addr", int'(wr_addr), 0);
    chk("reset.wr_data", int'(wr_data), 0);
    check_status("reset");

    send_str("0A 1b\r", 0);
    check_status("t1");

    pulse_clear();
    s = "";
    for (int i = 0; i < NV; i++) s = {s, $sformatf("%02X ", i)};
    send_str(s, 1);
    check_status("t2_done");
    send_str("FF ", 0);
    check_status("t2_after");

    pulse_clear();
    send_str("123 ", 0);
    check_status("t3_err");
    pulse_clear();
    send_str("5 ", 0);
    check_status("t3_after");

    pulse_clear();
    send_str("G", 0);
    check_status("t4_err");
    send_str("  3 ", 0);
    check_status("t4_after");

    pulse_clear();
    send_str("A", 0);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    send_str("7\n", 0);
    check_status("t5");

    pulse_clear();
    drive("4", 1'b0);
    drive(" ", 1'b1);
    check_status("t6_clr");
    send_str("9 ", 0);
    check_status("t6_after");

    for (int it = 0; it < 60; it++) begin
      pulse_clear();
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 99);
        if (r < 55) begin
          s = "0123456789ABCDEFabcdef";
          drive(s[$urandom_range(0, 21)], 1'b0);
        end else if (r < 92) begin
          s = " \t\r\n,";
          drive(s[$urandom_range(0, 4)], 1'b0);
        end else if (r < 96) begin
          s = "Gx-/:@g";
          drive(s[$urandom_range(0, 6)], 1'b0);
        end else begin
          drive(8'($urandom_range(0, 255)), 1'b1);
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      check_status($sformatf("rand%0d", it));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
